// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: pin synchronisation, clock glitch filter, frame
// FSM with inter-edge timeout, and make/break scan-code decoding.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keycode,
  output logic        byte_valid,
  output logic        make_valid,
  output logic        break_valid,
  output logic [7:0]  scan_code,
  output logic        extended,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] flt_cnt;
  logic          strobe;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          ext_pend, brk_pend;

  // Two-flop synchronisers for both asynchronous pins
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      dat_s1 <= 1'b0;
      dat_s2 <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: follow the synced clock only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_f   <= 1'b0;
      clk_f_d <= 1'b0;
      flt_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Filtered falling edge marks the bit sample point
  assign strobe = clk_f_d & ~clk_f;

  // Frame FSM, timeout and scan-code decode with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tcnt        <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      keycode     <= '0;
      byte_valid  <= 1'b0;
      make_valid  <= 1'b0;
      break_valid <= 1'b0;
      scan_code   <= '0;
      extended    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      make_valid  <= 1'b0;
      break_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            // A high start bit is line noise, not a frame
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && (^{par, shreg})) begin
              keycode    <= {keycode[23:0], shreg};
              byte_valid <= 1'b1;
              if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk_pend <= 1'b1;
              end else begin
                scan_code   <= shreg;
                extended    <= ext_pend;
                break_valid <= brk_pend;
                make_valid  <= ~brk_pend;
                ext_pend    <= 1'b0;
                brk_pend    <= 1'b0;
              end
            end else begin
              // Pending prefixes survive a dropped frame
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed table, hand-written corner sequences,
// and random frames checked against a scan-code level reference model.
module tb_ps2_keycode_rx;

  localparam int FLT  = 4;
  localparam int TOUT = 300;
  localparam int H    = 20;   // PS/2 half bit period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keycode;
  logic        byte_valid, make_valid, break_valid, extended, frame_err;
  logic [7:0]  scan_code;

  ps2_keycode_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .byte_valid(byte_valid), .make_valid(make_valid),
    .break_valid(break_valid), .scan_code(scan_code), .extended(extended),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_byte = 0, n_make = 0, n_brk = 0, n_err = 0, n_both = 0;
  int s_byte, s_make, s_brk, s_err;

  // reference model state
  logic [31:0] m_kc;
  logic [7:0]  m_scan;
  logic        m_ext, m_ext_p, m_brk_p;
  int          e_make, e_brk;

  // pulse monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid)  n_byte++;
      if (make_valid)  n_make++;
      if (break_valid) n_brk++;
      if (frame_err)   n_err++;
      if (make_valid && break_valid) n_both++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_kc = 0; m_scan = 0; m_ext = 0; m_ext_p = 0; m_brk_p = 0;
  endtask

  // model one frame: only good bytes touch the history and decode state
  task automatic model_frame(input logic [7:0] b, input bit good);
    e_make = 0; e_brk = 0;
    if (!good) return;
    m_kc = (m_kc << 8) | 32'(b);
    if (b == 8'hE0) m_ext_p = 1;
    else if (b == 8'hF0) m_brk_p = 1;
    else begin
      m_scan = b; m_ext = m_ext_p;
      if (m_brk_p) e_brk = 1; else e_make = 1;
      m_ext_p = 0; m_brk_p = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; ps2_clk = 1; ps2_data = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    model_reset();
    repeat (20) @(negedge clk);
  endtask

  task automatic snap();
    s_byte = n_byte; s_make = n_make; s_brk = n_brk; s_err = n_err;
  endtask

  // drive the first nbits of a frame (start, 8 data LSB first, parity, stop)
  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int nbits);
    logic [10:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    bits[9]  = ~(^b) ^ par_bad;
    bits[10] = ~stop_bad;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 0;
      repeat (H) @(negedge clk);
      ps2_clk = 1;
    end
    ps2_data = 1;
    repeat (30) @(negedge clk);
  endtask

  task automatic check_model(input string tag, input int err_exp, input int byte_exp);
    chk({tag, ".bytes"}, n_byte - s_byte, byte_exp);
    chk({tag, ".make"},  n_make - s_make, e_make);
    chk({tag, ".break"}, n_brk - s_brk, e_brk);
    chk({tag, ".err"},   n_err - s_err, err_exp);
    chk({tag, ".keycode"}, keycode, m_kc);
    chk({tag, ".scan"}, scan_code, m_scan);
    chk({tag, ".ext"}, extended, m_ext);
  endtask

  typedef struct {
    bit          do_rst;
    logic [7:0]  data;
    bit          par_bad;
    bit          stop_bad;
    logic [31:0] exp_kc;
    int          exp_byte, exp_make, exp_brk, exp_err;
    logic [7:0]  exp_scan;
    bit          exp_ext;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 8'h1D, 0, 0, 32'h0000001D, 1, 1, 0, 0, 8'h1D, 0};
    vt[1] = '{1, 8'h1D, 0, 0, 32'h0000001D, 1, 1, 0, 0, 8'h1D, 0};
    vt[2] = '{0, 8'hF0, 0, 0, 32'h00001DF0, 1, 0, 0, 0, 8'h1D, 0};
    vt[3] = '{0, 8'h1D, 0, 0, 32'h001DF01D, 1, 0, 1, 0, 8'h1D, 0};
    vt[4] = '{1, 8'hE0, 0, 0, 32'h000000E0, 1, 0, 0, 0, 8'h00, 0};
    vt[5] = '{0, 8'h75, 0, 0, 32'h0000E075, 1, 1, 0, 0, 8'h75, 1};
    vt[6] = '{0, 8'h23, 1, 0, 32'h0000E075, 0, 0, 0, 1, 8'h75, 1};
    vt[7] = '{0, 8'h23, 0, 1, 32'h0000E075, 0, 0, 0, 1, 8'h75, 1};

    // reset state
    do_reset();
    chk("reset.keycode", keycode, 32'h0);
    chk("reset.pulses", {byte_valid, make_valid, break_valid, frame_err}, 4'h0);
    chk("reset.scan_ext", {scan_code, extended}, 9'h0);

    // directed table
    for (int i = 0; i < 8; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      if (vt[i].do_rst) do_reset();
      snap();
      send_frame(vt[i].data, vt[i].par_bad, vt[i].stop_bad, 11);
      model_frame(vt[i].data, !(vt[i].par_bad || vt[i].stop_bad));
      chk({t, ".keycode"}, keycode, vt[i].exp_kc);
      chk({t, ".bytes"}, n_byte - s_byte, vt[i].exp_byte);
      chk({t, ".make"},  n_make - s_make, vt[i].exp_make);
      chk({t, ".break"}, n_brk - s_brk, vt[i].exp_brk);
      chk({t, ".err"},   n_err - s_err, vt[i].exp_err);
      chk({t, ".scan"},  scan_code, vt[i].exp_scan);
      chk({t, ".ext"},   extended, vt[i].exp_ext);
    end

    // prefix survives a bad frame: F0, bad frame, 1C -> break
    snap();
    send_frame(8'hF0, 0, 0, 11); model_frame(8'hF0, 1);
    send_frame(8'h44, 1, 0, 11); model_frame(8'h44, 0);
    send_frame(8'h1C, 0, 0, 11); model_frame(8'h1C, 1);
    chk("pend_keep.break", n_brk - s_brk, 1);
    chk("pend_keep.err", n_err - s_err, 1);
    chk("pend_keep.keycode", keycode, m_kc);

    // timeout after 4 data bits, then a clean frame
    snap();
    send_frame(8'h5A, 0, 0, 5);
    repeat (TOUT + 50) @(negedge clk);
    model_frame(8'h5A, 0);
    chk("timeout.err", n_err - s_err, 1);
    chk("timeout.bytes", n_byte - s_byte, 0);
    snap();
    send_frame(8'h1C, 0, 0, 11); model_frame(8'h1C, 1);
    check_model("after_timeout", 0, 1);
    chk("after_timeout.low", keycode[7:0], 8'h1C);

    // short clock glitch with data low must not start a frame
    snap();
    @(negedge clk); ps2_data = 0; ps2_clk = 0;
    repeat (FLT - 1) @(negedge clk);
    ps2_clk = 1;
    repeat (5) @(negedge clk); ps2_data = 1;
    repeat (TOUT + 50) @(negedge clk);
    chk("glitch.err", n_err - s_err, 0);
    chk("glitch.bytes", n_byte - s_byte, 0);

    // reset in the middle of a frame
    send_frame(8'h77, 0, 0, 4);
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("midrst.keycode", keycode, 32'h0);
    chk("midrst.outs", {byte_valid, make_valid, break_valid, frame_err, scan_code, extended}, 13'h0);
    rst = 0; model_reset();
    repeat (20) @(negedge clk);
    snap();
    send_frame(8'h6B, 0, 0, 11); model_frame(8'h6B, 1);
    check_model("after_rst", 0, 1);

    // random frames against the reference model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit pb, sb;
      int r;
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      pb = ($urandom_range(0, 9) == 0);
      sb = ($urandom_range(0, 19) == 0);
      snap();
      send_frame(b, pb, sb, 11);
      model_frame(b, !(pb || sb));
      check_model($sformatf("rnd%0d", i), (pb || sb) ? 1 : 0, (pb || sb) ? 0 : 1);
    end

    chk("make_break_exclusive", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
